// File: rtl/spi_master_multi.sv
// SPI master with per-request length, CPOL/CPHA, SCK divider and chip-select index.
// One request is taken in IDLE; captured MISO bits come back as a one-cycle response pulse.
module spi_master_multi #(
  parameter int unsigned MaxDataBits = 24,
  parameter int unsigned NumCs       = 2,
  parameter int unsigned ClkDivWidth = 8,
  parameter int unsigned LenWidth    = $clog2(MaxDataBits + 1),
  parameter int unsigned CsSelWidth  = (NumCs > 1) ? $clog2(NumCs) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_clk_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [MaxDataBits-1:0] req_data_i,
  input  logic [LenWidth-1:0]    req_len_i,
  input  logic [CsSelWidth-1:0]  req_cs_sel_i,
  input  logic                   req_cpol_i,
  input  logic                   req_cpha_i,
  input  logic [ClkDivWidth-1:0] req_clk_div_i,
  input  logic                   miso_i,
  output logic                   sck_o,
  output logic                   mosi_o,
  output logic [NumCs-1:0]       cs_n_o,
  output logic                   rsp_valid_o,
  output logic [MaxDataBits-1:0] rsp_data_o,
  output logic                   busy_o
);
  localparam int unsigned EdgeWidth = LenWidth + 1;

  typedef enum logic [2:0] {StIdle, StLoad, StSetup, StXfer, StHold, StGap} state_e;

  state_e                 state_q, state_d;
  logic [ClkDivWidth-1:0] div_q, div_d, cnt_q, cnt_d;
  logic [EdgeWidth-1:0]   edge_q, edge_d;
  logic [LenWidth-1:0]    len_q, len_d;
  logic [CsSelWidth-1:0]  cs_sel_q, cs_sel_d;
  logic                   cpol_q, cpol_d, cpha_q, cpha_d;
  logic [MaxDataBits-1:0] tx_q, tx_d, rx_q, rx_d, rsp_data_q, rsp_data_d;
  logic                   sck_q, sck_d, mosi_q, mosi_d, rsp_valid_q, rsp_valid_d;
  logic [NumCs-1:0]       cs_n_q, cs_n_d, cs_sel_n;

  logic [LenWidth-1:0]    req_len_clamped;
  logic [EdgeWidth-1:0]   edge_total;
  logic                   div_done, leading, last_edge;

  assign req_len_clamped = (req_len_i > LenWidth'(MaxDataBits)) ? LenWidth'(MaxDataBits)
                                                                 : req_len_i;
  assign div_done   = (cnt_q == div_q);
  assign leading    = (sck_q == cpol_q);
  assign edge_total = {len_q, 1'b0};
  assign last_edge  = (edge_q == edge_total - EdgeWidth'(1));

  // Out-of-range selects leave every chip select high.
  always_comb begin
    cs_sel_n = '1;
    for (int i = 0; i < int'(NumCs); i++) begin
      if (cs_sel_q == CsSelWidth'(i)) cs_sel_n[i] = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    edge_d      = edge_q;
    len_d       = len_q;
    cs_sel_d    = cs_sel_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    rsp_data_d  = rsp_data_q;
    sck_d       = sck_q;
    mosi_d      = mosi_q;
    cs_n_d      = cs_n_q;
    rsp_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          div_d    = req_clk_div_i;
          len_d    = req_len_clamped;
          cs_sel_d = req_cs_sel_i;
          cpol_d   = req_cpol_i;
          cpha_d   = req_cpha_i;
          sck_d    = req_cpol_i;
          // Left-align so the first bit out is always the shifter MSB.
          tx_d     = req_data_i << (LenWidth'(MaxDataBits) - req_len_clamped);
          rx_d     = '0;
          cnt_d    = '0;
          edge_d   = '0;
          state_d  = StLoad;
        end
      end
      StLoad: begin
        if (len_q == '0) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = rx_q;
          state_d     = StGap;
        end else begin
          cs_n_d  = cs_sel_n;
          state_d = StSetup;
          if (!cpha_q) begin
            mosi_d = tx_q[MaxDataBits-1];
            tx_d   = tx_q << 1;
          end
        end
      end
      StSetup: begin
        if (div_done) begin
          cnt_d   = '0;
          state_d = StXfer;
        end else begin
          cnt_d = cnt_q + ClkDivWidth'(1);
        end
      end
      StXfer: begin
        if (div_done) begin
          cnt_d  = '0;
          sck_d  = ~sck_q;
          edge_d = edge_q + EdgeWidth'(1);
          if (leading ^ cpha_q) begin
            rx_d = {rx_q[MaxDataBits-2:0], miso_i};
          end else if (!last_edge) begin
            mosi_d = tx_q[MaxDataBits-1];
            tx_d   = tx_q << 1;
          end
          if (last_edge) state_d = StHold;
        end else begin
          cnt_d = cnt_q + ClkDivWidth'(1);
        end
      end
      StHold: begin
        if (div_done) begin
          cnt_d       = '0;
          cs_n_d      = '1;
          rsp_valid_d = 1'b1;
          rsp_data_d  = rx_q;
          state_d     = StGap;
        end else begin
          cnt_d = cnt_q + ClkDivWidth'(1);
        end
      end
      StGap: begin
        if (div_done) begin
          cnt_d   = '0;
          mosi_d  = 1'b0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + ClkDivWidth'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_clk_i) begin
    if (rst_clk_i) begin
      state_q     <= StIdle;
      div_q       <= '0;
      cnt_q       <= '0;
      edge_q      <= '0;
      len_q       <= '0;
      cs_sel_q    <= '0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      rsp_data_q  <= '0;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
      cs_n_q      <= '1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      edge_q      <= edge_d;
      len_q       <= len_d;
      cs_sel_q    <= cs_sel_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rsp_data_q  <= rsp_data_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
      cs_n_q      <= cs_n_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign req_ready_o = (state_q == StIdle);
  assign busy_o      = (state_q != StIdle);
  assign sck_o       = sck_q;
  assign mosi_o      = mosi_q;
  assign cs_n_o      = cs_n_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// Bench for spi_master_multi: directed scenarios plus random transfers against a
// transaction-level model of SPI framing, timing and chip-select behaviour.
module tb_spi_master_multi;
  localparam int unsigned MaxBits = 24;
  localparam int unsigned NCs     = 3;  // three selects so an index >= NumCs is representable

  logic         clk_i = 1'b0;
  logic         rst_clk_i;
  logic         req_valid_i, req_ready_o;
  logic [23:0]  req_data_i;
  logic [4:0]   req_len_i;
  logic [1:0]   req_cs_sel_i;
  logic         req_cpol_i, req_cpha_i;
  logic [7:0]   req_clk_div_i;
  logic         miso_i, sck_o, mosi_o, rsp_valid_o, busy_o;
  logic [2:0]   cs_n_o;
  logic [23:0]  rsp_data_o;
  logic         loop_en, slave_miso;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  assign miso_i = loop_en ? mosi_o : slave_miso;

  spi_master_multi #(
    .MaxDataBits(MaxBits),
    .NumCs      (NCs),
    .ClkDivWidth(8)
  ) dut (
    .clk_i        (clk_i),
    .rst_clk_i    (rst_clk_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_data_i   (req_data_i),
    .req_len_i    (req_len_i),
    .req_cs_sel_i (req_cs_sel_i),
    .req_cpol_i   (req_cpol_i),
    .req_cpha_i   (req_cpha_i),
    .req_clk_div_i(req_clk_div_i),
    .miso_i       (miso_i),
    .sck_o        (sck_o),
    .mosi_o       (mosi_o),
    .cs_n_o       (cs_n_o),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_data_o   (rsp_data_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] lmask(input int len);
    logic [23:0] ones;
    ones = 24'hFF_FFFF;
    return (len == 0) ? 24'h0 : (ones >> (24 - len));
  endfunction

  // Issues one request and observes the whole frame until the master is idle again.
  task automatic do_xfer(input string tag, input logic [23:0] data, input int len_req,
                         input int sel, input bit cpol, input bit cpha, input int div,
                         input bit loop, input logic [23:0] sdata);
    int len, h, t_acc, t_rsp, n_rsp, tog, sidx, both, w;
    int cs_low [NCs];
    int exp_low;
    logic prev_sck, lead;
    logic [23:0] mosi_cap, rsp_cap, exp_rx;

    len = (len_req > 24) ? 24 : len_req;
    h = div + 1;
    t_rsp = -1; n_rsp = 0; tog = 0; both = 0;
    mosi_cap = '0; rsp_cap = '0;
    for (int i = 0; i < NCs; i++) cs_low[i] = 0;
    exp_rx = loop ? (data & lmask(len)) : (sdata & lmask(len));

    loop_en = loop;
    req_data_i = data; req_len_i = 5'(len_req); req_cs_sel_i = 2'(sel);
    req_cpol_i = cpol; req_cpha_i = cpha; req_clk_div_i = 8'(div);
    req_valid_i = 1'b1;
    w = 0;
    while (!req_ready_o && w < 500) begin
      @(negedge clk_i);
      w++;
    end
    t_acc = cyc;
    if (!cpha && len > 0) begin
      sidx = len - 1;
      slave_miso = sdata[sidx];
    end else begin
      sidx = len;
      slave_miso = 1'b0;
    end
    @(negedge clk_i);
    req_valid_i = 1'b0;
    check({tag, " load_sck"}, sck_o, cpol);
    prev_sck = sck_o;

    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NCs; i++) if (!cs_n_o[i]) cs_low[i]++;
      if ($countones(~cs_n_o) > 1) both++;
      if (rsp_valid_o) begin
        n_rsp++;
        t_rsp = cyc;
        rsp_cap = rsp_data_o;
      end
      if (sck_o !== prev_sck) begin
        tog++;
        lead = (sck_o != cpol);
        if (lead != cpha) begin
          mosi_cap = {mosi_cap[22:0], mosi_o};
        end else if (!loop && sidx > 0) begin
          sidx--;
          slave_miso = sdata[sidx];
        end
        prev_sck = sck_o;
      end
      if (n_rsp > 0 && !busy_o) break;
      @(negedge clk_i);
    end

    for (int i = 0; i < NCs; i++) begin
      exp_low = (i == sel && len > 0) ? h * (2 * len + 2) : 0;
      check($sformatf("%s cs%0d_low", tag, i), 64'(cs_low[i]), 64'(exp_low));
    end
    check({tag, " sck_toggles"}, 64'(tog), 64'(2 * len));
    check({tag, " mosi_stream"}, mosi_cap, data & lmask(len));
    check({tag, " rsp_count"}, 64'(n_rsp), 64'd1);
    check({tag, " rsp_data"}, rsp_cap, exp_rx);
    check({tag, " rsp_time"}, 64'(t_rsp - t_acc), 64'((len > 0) ? 2 + h * (2 * len + 2) : 2));
    check({tag, " cs_overlap"}, 64'(both), 64'd0);
    check({tag, " idle_sck"}, sck_o, cpol);
    check({tag, " idle_mosi"}, mosi_o, 1'b0);
  endtask

  initial begin
    int w, tog, rsp_seen, rose0, fell1, ready_rise, acc2, both;
    logic prev_sck;
    logic [2:0] prev_cs;

    rst_clk_i = 1'b1; req_valid_i = 1'b0; req_data_i = '0; req_len_i = '0;
    req_cs_sel_i = '0; req_cpol_i = 1'b0; req_cpha_i = 1'b0; req_clk_div_i = '0;
    loop_en = 1'b1; slave_miso = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst cs_n", cs_n_o, 3'b111);
    check("rst sck", sck_o, 1'b0);
    check("rst mosi", mosi_o, 1'b0);
    check("rst rsp_valid", rsp_valid_o, 1'b0);
    check("rst rsp_data", rsp_data_o, 24'h0);
    check("rst busy", busy_o, 1'b0);
    check("rst ready", req_ready_o, 1'b1);
    rst_clk_i = 1'b0;
    @(negedge clk_i);

    do_xfer("mode0", 24'h000A5C, 24, 0, 1'b0, 1'b0, 0, 1'b1, 24'h0);
    do_xfer("mode3", 24'h00003C, 8, 1, 1'b1, 1'b1, 3, 1'b0, 24'h0000A5);
    do_xfer("len0", 24'h123456, 0, 0, 1'b0, 1'b0, 2, 1'b1, 24'h0);
    do_xfer("len30", 24'hC3_5A_96, 30, 1, 1'b0, 1'b1, 1, 1'b0, 24'h9A_BC_DE);
    do_xfer("cs_oob", 24'h0000F0, 8, 3, 1'b1, 1'b0, 0, 1'b1, 24'h0);

    // Back-to-back with valid held high: sel 0 then sel 1.
    loop_en = 1'b1;
    req_data_i = 24'h0000AA; req_len_i = 5'd8; req_cs_sel_i = 2'd0;
    req_cpol_i = 1'b0; req_cpha_i = 1'b0; req_clk_div_i = 8'd1;
    req_valid_i = 1'b1;
    w = 0;
    while (!req_ready_o && w < 100) begin
      @(negedge clk_i);
      w++;
    end
    @(negedge clk_i);
    req_data_i = 24'h000055; req_cs_sel_i = 2'd1;
    rose0 = -1; fell1 = -1; ready_rise = -1; acc2 = -1; both = 0;
    prev_cs = cs_n_o;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk_i);
      if (cs_n_o[0] && !prev_cs[0] && rose0 < 0) rose0 = cyc;
      if (!cs_n_o[1] && prev_cs[1] && fell1 < 0) fell1 = cyc;
      if ($countones(~cs_n_o) > 1) both++;
      if (req_ready_o && ready_rise < 0) ready_rise = cyc;
      if (ready_rise >= 0 && acc2 < 0 && busy_o) begin
        acc2 = cyc;
        req_valid_i = 1'b0;
      end
      prev_cs = cs_n_o;
      if (acc2 >= 0 && !busy_o) break;
    end
    req_valid_i = 1'b0;
    check("b2b accept", 64'(acc2 - ready_rise), 64'd1);
    check("b2b cs_gap", 64'((rose0 >= 0 && fell1 >= 0 && fell1 - rose0 >= 3) ? 1 : 0), 64'd1);
    check("b2b overlap", 64'(both), 64'd0);

    // Reset in the middle of a 24-bit frame.
    loop_en = 1'b1;
    req_data_i = 24'hFEDCBA; req_len_i = 5'd24; req_cs_sel_i = 2'd0;
    req_cpol_i = 1'b1; req_cpha_i = 1'b0; req_clk_div_i = 8'd1;
    req_valid_i = 1'b1;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    @(negedge clk_i);
    prev_sck = sck_o; tog = 0; w = 0;
    while (tog < 20 && w < 500) begin
      @(negedge clk_i);
      w++;
      if (sck_o !== prev_sck) tog++;
      prev_sck = sck_o;
    end
    check("mid toggles", 64'(tog), 64'd20);
    rst_clk_i = 1'b1;
    #1;
    check("mid cs_n", cs_n_o, 3'b111);
    check("mid sck", sck_o, 1'b0);
    check("mid busy", busy_o, 1'b0);
    check("mid ready", req_ready_o, 1'b1);
    rsp_seen = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk_i);
      if (rsp_valid_o) rsp_seen++;
    end
    rst_clk_i = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk_i);
      if (rsp_valid_o) rsp_seen++;
    end
    check("mid no_rsp", 64'(rsp_seen), 64'd0);
    check("mid rsp_data", rsp_data_o, 24'h0);
    do_xfer("post_rst", 24'h00BEEF, 16, 1, 1'b0, 1'b1, 2, 1'b1, 24'h0);

    for (int k = 0; k < 12; k++) begin
      do_xfer($sformatf("rand%0d", k), 24'($urandom), $urandom_range(0, 26),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)), 24'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
